// File: rtl/muldiv_pkg.sv
// Shared constants, FSM state type and sign fix-up helper for the RV64M
// iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 64;
  localparam int CNTW = $clog2(XLEN + 1);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] MUL    = 3'd0;
  localparam logic [2:0] MULH   = 3'd1;
  localparam logic [2:0] MULHSU = 3'd2;
  localparam logic [2:0] MULHU  = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] DIVU   = 3'd5;
  localparam logic [2:0] REM    = 3'd6;
  localparam logic [2:0] REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } stateT;

  // Conditional two's-complement negate of one XLEN slice; cin carries the
  // +1 in from the lower slice so two calls negate a 2*XLEN value.
  function automatic logic [XLEN-1:0] condNeg(input logic [XLEN-1:0] v,
                                              input logic neg,
                                              input logic cin);
    return neg ? (~v + {{(XLEN-1){1'b0}}, cin}) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add multiply, restoring divide,
// one result bit per cycle, with a short path for divide special cases.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            reg_write
);

  stateT           state, stateNext;
  logic [CNTW-1:0] count;
  logic [2:0]      op;
  logic [4:0]      rdReg;
  logic [XLEN-1:0] operand, accHi, accLo;
  logic            negRes, negRem, special;

  logic            isDiv, signA, signB, divZero, overflow;
  logic [XLEN-1:0] absA, absB, specialVal;

  always_comb begin
    isDiv    = funct3[2];
    signA    = (funct3 == MULH || funct3 == MULHSU || funct3 == DIV || funct3 == REM)
               && op_a[XLEN-1];
    signB    = (funct3 == MULH || funct3 == DIV || funct3 == REM) && op_b[XLEN-1];
    absA     = condNeg(op_a, signA, 1'b1);
    absB     = condNeg(op_b, signB, 1'b1);
    divZero  = isDiv && (op_b == '0);
    overflow = (funct3 == DIV || funct3 == REM) && (op_a == MIN_NEG) && (op_b == '1);
    specialVal = '0;
    if (divZero)       specialVal = funct3[1] ? op_a : '1;
    else if (overflow) specialVal = funct3[1] ? '0 : op_a;
  end

  logic [XLEN:0]   mulSum, divDiff;
  logic [XLEN-1:0] negLo, negHi, remFix, finalVal;

  always_comb begin
    mulSum  = {1'b0, accHi} + (accLo[0] ? {1'b0, operand} : '0);
    divDiff = {accHi, accLo[XLEN-1]} - {1'b0, operand};
    negLo   = condNeg(accLo, negRes, 1'b1);
    negHi   = condNeg(accHi, negRes, accLo == '0);
    remFix  = condNeg(accHi, negRem, 1'b1);
    if (!op[2]) finalVal = (op == MUL) ? negLo : negHi;
    else        finalVal = op[1] ? remFix : negLo;
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) stateNext = CALC;
      CALC: begin
        busy = 1'b1;
        if (special || count == CNTW'(XLEN)) stateNext = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    reg_write = done && (rd_out != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Special cases spend one CALC cycle so result still changes only when
  // entering DONE; the extra CALC step at count == XLEN applies sign fix-up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      op      <= '0;
      rdReg   <= '0;
      operand <= '0;
      accHi   <= '0;
      accLo   <= '0;
      negRes  <= 1'b0;
      negRem  <= 1'b0;
      special <= 1'b0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op      <= funct3;
          rdReg   <= rd_in;
          count   <= '0;
          special <= divZero || overflow;
          negRes  <= signA ^ signB;
          negRem  <= signA;
          accHi   <= '0;
          if (isDiv) begin
            operand <= absB;
            accLo   <= (divZero || overflow) ? specialVal : absA;
          end else begin
            operand <= absA;
            accLo   <= absB;
          end
        end
        CALC: begin
          if (special) begin
            result <= accLo;
            rd_out <= rdReg;
          end else if (count == CNTW'(XLEN)) begin
            result <= finalVal;
            rd_out <= rdReg;
          end else begin
            count <= count + 1'b1;
            if (op[2]) begin
              if (!divDiff[XLEN]) begin
                accHi <= divDiff[XLEN-1:0];
                accLo <= {accLo[XLEN-2:0], 1'b1};
              end else begin
                accHi <= {accHi[XLEN-2:0], accLo[XLEN-1]};
                accLo <= {accLo[XLEN-2:0], 1'b0};
              end
            end else begin
              {accHi, accLo} <= {mulSum, accLo[XLEN-1:1]};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
